// File: rtl/dht11_controller_pkg.sv
// Shared definitions for the DHT11 single-wire controller: FSM state encodings,
// frame layout constants and the frame checksum helpers.
package dht11_controller_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_LOW = 4'd1,
        ST_RELEASE   = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_CHECK     = 4'd7
    } dht_state_t;

    localparam int FRAME_BITS  = 40;
    localparam int FRAME_BYTES = 5;

    // Byte positions in wire order; byte 0 arrives first (MSB of the frame).
    localparam int HUMI_I = 0;
    localparam int HUMI_D = 1;
    localparam int TEMP_I = 2;
    localparam int TEMP_D = 3;
    localparam int PARITY = 4;

    localparam int US_CNT_W  = 16;
    localparam int BIT_IDX_W = 6;

    function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame,
                                              input int idx);
        return frame[(FRAME_BITS - 1) - 8 * idx -: 8];
    endfunction

    function automatic logic [7:0] frame_checksum(input logic [FRAME_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame_byte(frame, HUMI_I) + frame_byte(frame, HUMI_D)
            + frame_byte(frame, TEMP_I) + frame_byte(frame, TEMP_D);
        return sum;
    endfunction

endpackage

// File: rtl/dht11_controller_tick_gen_us.sv
// Free-running microsecond strobe: one-clock pulse every CLK_FREQ_HZ/1e6 clocks.
module tick_gen_us
    import dht11_controller_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic us_tick
);

    localparam int DIV_RAW = CLK_FREQ_HZ / 1_000_000;
    localparam int DIV     = (DIV_RAW > 0) ? DIV_RAW : 1;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            us_tick <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
            us_tick <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            us_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dht11_controller.sv
// DHT11 single-wire master: issues the start pulse, decodes the 40-bit frame and
// publishes checksum-verified bytes to the display path.
module dht11_controller
    import dht11_controller_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int START_LOW_US  = 18000,
    parameter int RELEASE_US    = 30,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    inout  wire        dht_io,
    output logic [7:0] humi_integral,
    output logic [7:0] humi_decimal,
    output logic [7:0] temp_integral,
    output logic [7:0] temp_decimal,
    output logic [7:0] parity,
    output logic       data_valid,
    output logic       chk_err,
    output logic       timeout_err,
    output logic       busy
);

    localparam logic [US_CNT_W-1:0]  START_LOW_TICKS  = US_CNT_W'(START_LOW_US);
    localparam logic [US_CNT_W-1:0]  RELEASE_TICKS    = US_CNT_W'(RELEASE_US);
    localparam logic [US_CNT_W-1:0]  TIMEOUT_TICKS    = US_CNT_W'(TIMEOUT_US);
    localparam logic [US_CNT_W-1:0]  BIT_THRESH_TICKS = US_CNT_W'(BIT_THRESH_US);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX     = BIT_IDX_W'(FRAME_BITS - 1);

    dht_state_t state;
    dht_state_t state_next;

    logic                  us_tick;
    logic [1:0]            line_sync;
    logic                  line;
    logic                  line_prev;
    logic                  line_rise;
    logic                  line_fall;
    logic [US_CNT_W-1:0]   us_cnt;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  timed_out;
    logic                  bit_value;
    logic                  frame_ok;
    logic                  shift_en;
    logic                  idx_clear;
    logic                  load_out;
    logic                  flag_chk;
    logic                  flag_timeout;

    tick_gen_us #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .us_tick(us_tick)
    );

    // Two-flop synchronizer; reset to the idle-high level so no false edge appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_sync <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            line_sync <= {line_sync[0], dht_io};
            line_prev <= line_sync[1];
        end
    end

    assign line      = line_sync[1];
    assign line_rise = line & ~line_prev;
    assign line_fall = ~line & line_prev;

    assign timed_out = (us_cnt > TIMEOUT_TICKS);
    assign bit_value = (us_cnt >= BIT_THRESH_TICKS);
    assign frame_ok  = (frame_checksum(shift_reg) == frame_byte(shift_reg, PARITY));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        shift_en     = 1'b0;
        idx_clear    = 1'b0;
        load_out     = 1'b0;
        flag_chk     = 1'b0;
        flag_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_START_LOW;
                end
            end
            ST_START_LOW: begin
                if (us_cnt >= START_LOW_TICKS) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (us_cnt >= RELEASE_TICKS) begin
                    state_next = ST_RESP_LOW;
                end
            end
            // A rising edge can only follow the sensor's response low, so it marks both.
            ST_RESP_LOW: begin
                if (timed_out) begin
                    flag_timeout = 1'b1;
                    state_next   = ST_IDLE;
                end else if (line_rise) begin
                    state_next = ST_RESP_HIGH;
                end
            end
            ST_RESP_HIGH: begin
                if (timed_out) begin
                    flag_timeout = 1'b1;
                    state_next   = ST_IDLE;
                end else if (line_fall) begin
                    idx_clear  = 1'b1;
                    state_next = ST_BIT_LOW;
                end
            end
            ST_BIT_LOW: begin
                if (timed_out) begin
                    flag_timeout = 1'b1;
                    state_next   = ST_IDLE;
                end else if (line_rise) begin
                    state_next = ST_BIT_HIGH;
                end
            end
            ST_BIT_HIGH: begin
                if (timed_out) begin
                    flag_timeout = 1'b1;
                    state_next   = ST_IDLE;
                end else if (line_fall) begin
                    shift_en   = 1'b1;
                    state_next = (bit_idx == LAST_BIT_IDX) ? ST_CHECK : ST_BIT_LOW;
                end
            end
            ST_CHECK: begin
                state_next = ST_IDLE;
                if (frame_ok) begin
                    load_out = 1'b1;
                end else begin
                    flag_chk = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Restarting at the current tick keeps measured widths exact: a high of N us counts N.
    always_ff @(posedge clk) begin
        if (rst) begin
            us_cnt <= '0;
        end else if (state_next != state) begin
            us_cnt <= {{(US_CNT_W - 1){1'b0}}, us_tick};
        end else if (us_tick && (us_cnt != '1)) begin
            us_cnt <= us_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (idx_clear) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], bit_value};
            end
        end
    end

    // Status pulses are registered so they coincide with the refreshed bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            humi_integral <= 8'h00;
            humi_decimal  <= 8'h00;
            temp_integral <= 8'h00;
            temp_decimal  <= 8'h00;
            parity        <= 8'h00;
            data_valid    <= 1'b0;
            chk_err       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            data_valid  <= load_out;
            chk_err     <= flag_chk;
            timeout_err <= flag_timeout;
            if (load_out) begin
                humi_integral <= frame_byte(shift_reg, HUMI_I);
                humi_decimal  <= frame_byte(shift_reg, HUMI_D);
                temp_integral <= frame_byte(shift_reg, TEMP_I);
                temp_decimal  <= frame_byte(shift_reg, TEMP_D);
                parity        <= frame_byte(shift_reg, PARITY);
            end
        end
    end

    assign busy   = (state != ST_IDLE);
    assign dht_io = (state == ST_START_LOW) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht11_controller.sv
// Scoreboard bench for dht11_controller with a behavioural DHT11 sensor on a pulled-up line.
module tb_dht11_controller;

    localparam int CLK_HZ  = 2_000_000;
    localparam int HALF_T  = 250;
    localparam int US_T    = 1000;
    localparam int BUDGET  = 20000;

    localparam logic [2:0] K_NONE    = 3'b000;
    localparam logic [2:0] K_VALID   = 3'b001;
    localparam logic [2:0] K_CHK     = 3'b010;
    localparam logic [2:0] K_TIMEOUT = 3'b100;

    typedef struct packed {
        logic [2:0]  kind;
        logic [39:0] bytes;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    wire        dht_io;
    logic [7:0] humi_integral;
    logic [7:0] humi_decimal;
    logic [7:0] temp_integral;
    logic [7:0] temp_decimal;
    logic [7:0] parity;
    logic       data_valid;
    logic       chk_err;
    logic       timeout_err;
    logic       busy;

    int          checks;
    int          errors;
    exp_t        sb_q[$];
    logic [39:0] last_good;
    longint      timeout_seen_t;

    logic   model_low;
    bit     model_respond;
    bit     model_busy;
    bit     model_in_high;
    int     model_bit;
    int     model_high[40];
    longint host_low_t;

    pullup (dht_io);
    assign dht_io = model_low ? 1'b0 : 1'bz;

    dht11_controller #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .START_LOW_US (100),
        .RELEASE_US   (30),
        .TIMEOUT_US   (200),
        .BIT_THRESH_US(40)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dht_io       (dht_io),
        .humi_integral(humi_integral),
        .humi_decimal (humi_decimal),
        .temp_integral(temp_integral),
        .temp_decimal (temp_decimal),
        .parity       (parity),
        .data_valid   (data_valid),
        .chk_err      (chk_err),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #HALF_T clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input longint actual,
                              input longint lo, input longint hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Sensor: answers a host start with the response pulses and the 40 bits.
    initial begin : sensor_model
        longint t_fall;
        model_low     = 1'b0;
        model_busy    = 1'b0;
        model_in_high = 1'b0;
        model_bit     = -1;
        host_low_t    = 0;
        forever begin
            @(negedge dht_io);
            t_fall = $time;
            @(posedge dht_io);
            host_low_t = $time - t_fall;
            if (model_respond) begin
                model_busy = 1'b1;
                #(100 + 20 * US_T) model_low = 1'b1;
                #(80 * US_T) model_low = 1'b0;
                #(80 * US_T);
                for (int i = 0; i < 40; i++) begin
                    model_bit     = i;
                    model_low     = 1'b1;
                    #(50 * US_T);
                    model_low     = 1'b0;
                    model_in_high = 1'b1;
                    #(model_high[i] * US_T);
                    model_in_high = 1'b0;
                end
                model_low = 1'b1;
                #(50 * US_T);
                model_low  = 1'b0;
                model_bit  = -1;
                model_busy = 1'b0;
            end
        end
    end

    // Pops one expectation for every status pulse the DUT raises.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_valid || chk_err || timeout_err) begin
                if (timeout_err) begin
                    timeout_seen_t = $time;
                end
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_event: got flags %b, expected no event",
                             {timeout_err, chk_err, data_valid});
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("event_kind", 64'({timeout_err, chk_err, data_valid}), 64'(e.kind));
                    checkOutput("output_bytes",
                                64'({humi_integral, humi_decimal, temp_integral, temp_decimal, parity}),
                                64'(e.bytes));
                end
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: got no completion within 90000 cycles, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [39:0] frame, input bit respond,
                                 input bit edge_bits, input logic [2:0] kind);
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            model_high[i] = frame[39 - i] ? 70 : 26;
        end
        if (edge_bits) begin
            model_high[0] = 26;
            model_high[1] = 70;
            model_high[2] = 39;
            model_high[3] = 40;
        end
        model_respond = respond;
        if (kind == K_VALID) begin
            e.kind    = kind;
            e.bytes   = frame;
            last_good = frame;
            sb_q.push_back(e);
        end else if (kind != K_NONE) begin
            e.kind  = kind;
            e.bytes = last_good;
            sb_q.push_back(e);
        end
        pulseStart();
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy || model_busy) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 64'(n < BUDGET), 64'd1);
        if (n >= BUDGET) begin
            sb_q.delete();
        end
    endtask

    task automatic waitForBit(input int idx);
        int n;
        n = 0;
        while (!(model_bit == idx && model_in_high) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("reach_bit_%0d", idx), 64'(n < BUDGET), 64'd1);
    endtask

    initial begin : stimulus
        int     n;
        longint t_rel;
        checks        = 0;
        errors        = 0;
        last_good     = '0;
        rst           = 1'b1;
        start         = 1'b0;
        model_respond = 1'b0;
        timeout_seen_t = 0;
        repeat (4) @(negedge clk);

        checkOutput("reset_bytes",
                    64'({humi_integral, humi_decimal, temp_integral, temp_decimal, parity}), 64'd0);
        checkOutput("reset_flags", 64'({data_valid, chk_err, timeout_err, busy}), 64'd0);
        checkOutput("reset_line", 64'(dht_io), 64'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] good frame 37 00 19 05 55");
        applyStimulus(40'h37_00_19_05_55, 1'b1, 1'b0, K_VALID);
        waitDone("frame1_done");
        checkRange("host_low_width", host_low_t, 99 * US_T, 101 * US_T);
        checkOutput("busy_after_frame1", 64'(busy), 64'd0);

        $display("[TB] bad parity frame");
        applyStimulus(40'h37_00_19_05_54, 1'b1, 1'b0, K_CHK);
        waitDone("frame2_done");

        $display("[TB] silent sensor");
        applyStimulus(40'h0, 1'b0, 1'b0, K_TIMEOUT);
        n = 0;
        while (dht_io !== 1'b0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        while (dht_io !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        t_rel = $time;
        checkOutput("release_seen", 64'(n < BUDGET), 64'd1);
        waitDone("timeout_done");
        checkRange("timeout_latency", timeout_seen_t - t_rel, 229 * US_T, 233 * US_T);
        checkOutput("line_after_timeout", 64'(dht_io), 64'd1);

        $display("[TB] bit width edges 26/70/39/40 us");
        applyStimulus(40'h50_12_1A_03_7F, 1'b1, 1'b1, K_VALID);
        waitDone("frame4_done");

        $display("[TB] start during bit 12");
        applyStimulus(40'h41_02_17_09_63, 1'b1, 1'b0, K_VALID);
        waitForBit(12);
        pulseStart();
        waitDone("frame5_done");
        repeat (20) @(negedge clk);
        checkOutput("no_queued_read", 64'({busy, dht_io}), 64'b01);

        $display("[TB] reset during bit 20");
        applyStimulus(40'h11_22_33_44_AA, 1'b1, 1'b0, K_NONE);
        waitForBit(20);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_line", 64'(dht_io), 64'd1);
        checkOutput("abort_bytes",
                    64'({humi_integral, humi_decimal, temp_integral, temp_decimal, parity}), 64'd0);
        rst       = 1'b0;
        last_good = '0;
        waitDone("abort_settled");
        applyStimulus(40'h2D_01_1C_07_51, 1'b1, 1'b0, K_VALID);
        waitDone("frame6_done");

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
